sklansky_addsub_pipe: RTL and testbench

SKLANSKY_ADDSUB_PIPE -- requirements
Module: sklansky_addsub_pipe

---
 rtl/sklansky_addsub_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_sklansky_addsub_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sklansky_addsub_pipe.sv
// Two-stage add/sub/absdiff/accumulate unit built on Sklansky parallel-prefix
// adders. S1 registers the operand beat, S2 registers the result and flags.
// Both stages and the accumulator move together on a single advance signal.

// Sklansky prefix adder: s = x + y + ci, co = carry out of the top bit.
module sklansky_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    localparam int L = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]      p0;
    logic [L:0][W-1:0] gt;
    logic [L:0][W-1:0] pt;

    assign p0 = x ^ y;

    // Prefix tree: at level l every bit with bit l of its index set combines
    // with the top bit of the lower half of its 2^(l+1) group. Carry-in is
    // folded into bit 0 so gt[L][i] is the carry out of bit i.
    always_comb begin
        gt = '0;
        pt = '0;
        gt[0] = x & y;
        pt[0] = p0;
        gt[0][0] = (x[0] & y[0]) | (p0[0] & ci);
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < W; i++) begin
                if (((i >> l) & 1) == 1) begin
                    gt[l+1][i] = gt[l][i] | (pt[l][i] & gt[l][((i >> l) << l) - 1]);
                    pt[l+1][i] = pt[l][i] & pt[l][((i >> l) << l) - 1];
                end else begin
                    gt[l+1][i] = gt[l][i];
                    pt[l+1][i] = pt[l][i];
                end
            end
        end
    end

    assign s  = p0 ^ {gt[L][W-2:0], ci};
    assign co = gt[L][W-1];
endmodule

module sklansky_addsub_pipe #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sat
);
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ABS = 2'b10,
        OP_ACC = 2'b11
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        op_e              op;
        logic             acc_clr;
    } s1_t;

    logic             advance;
    logic             s1_valid;
    s1_t              s1_q;
    logic [ACC_W-1:0] acc;

    // Whole pipe moves only when the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Main adder: a+b+cin for ADD, a+~b+cin for SUB, a-b for ABS/ACC.
    logic             is_arith;
    logic [WIDTH-1:0] y_main;
    logic             c_main;
    logic [WIDTH-1:0] s_main;
    logic             co_main;

    assign is_arith = (s1_q.op == OP_ADD) || (s1_q.op == OP_SUB);
    assign y_main   = (s1_q.op == OP_ADD) ? s1_q.b : ~s1_q.b;
    assign c_main   = is_arith ? s1_q.cin : 1'b1;

    sklansky_add #(.W(WIDTH)) u_main (
        .x (s1_q.a),
        .y (y_main),
        .ci(c_main),
        .s (s_main),
        .co(co_main)
    );

    // Reverse difference b-a; selected when b >= a to form |a-b|.
    logic [WIDTH-1:0] s_rev;
    logic             co_rev;
    logic [WIDTH-1:0] abs_val;

    sklansky_add #(.W(WIDTH)) u_rev (
        .x (s1_q.b),
        .y (~s1_q.a),
        .ci(1'b1),
        .s (s_rev),
        .co(co_rev)
    );

    assign abs_val = co_rev ? s_rev : s_main;

    // Accumulator adder; carry out means the sum no longer fits and clips.
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] abs_ext;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_co;
    logic [ACC_W-1:0] acc_nxt;

    // Zero-extend |a-b| into the accumulator width.
    always_comb begin
        abs_ext = '0;
        abs_ext[WIDTH-1:0] = abs_val;
    end

    assign acc_base = s1_q.acc_clr ? '0 : acc;

    sklansky_add #(.W(ACC_W)) u_acc (
        .x (acc_base),
        .y (abs_ext),
        .ci(1'b0),
        .s (acc_sum),
        .co(acc_co)
    );

    assign acc_nxt = acc_co ? '1 : acc_sum;

    // Result and flag selection for the beat sitting in S1.
    logic [ACC_W-1:0] res;
    logic             res_ovf;
    logic             res_sat;

    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_sat = 1'b0;
        case (s1_q.op)
            OP_ADD: begin
                res[WIDTH:0] = {co_main, s_main};
                res_ovf = (s1_q.a[WIDTH-1] == y_main[WIDTH-1]) &&
                          (s_main[WIDTH-1] != s1_q.a[WIDTH-1]);
            end
            OP_SUB: begin
                res[WIDTH-1:0] = s_main;
                res_ovf = (s1_q.a[WIDTH-1] == y_main[WIDTH-1]) &&
                          (s_main[WIDTH-1] != s1_q.a[WIDTH-1]);
            end
            OP_ABS: res[WIDTH-1:0] = abs_val;
            OP_ACC: begin
                res     = acc_nxt;
                res_sat = acc_co;
            end
            default: ;
        endcase
    end

    // S1: capture an accepted beat, or a bubble when advancing without one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_q <= '{a: a, b: b, cin: cin, op: op_e'(op), acc_clr: acc_clr};
        end
    end

    // S2 and accumulator: ACCUM beats write acc as they enter S2, so the
    // next beat in S1 always sees the freshly written value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            sat       <= 1'b0;
            acc       <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= res;
                cout <= co_main;
                ovf  <= res_ovf;
                sat  <= res_sat;
                if (s1_q.op == OP_ACC)
                    acc <= acc_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sklansky_addsub_pipe.sv
// Directed bench for sklansky_addsub_pipe (WIDTH=8, ACC_W=16).
module tb_sklansky_addsub_pipe;
    localparam int W  = 8;
    localparam int AW = 16;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ABS = 2'b10, ACC = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic          cin;
    logic [1:0]    op;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] sum;
    logic          cout, ovf, sat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sklansky_addsub_pipe #(.WIDTH(W), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .sat(sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic c, input logic cl);
        in_valid = 1'b1; op = o; a = x; b = y; cin = c; acc_clr = cl;
    endtask

    // Deassert in_valid and scramble the don't-care inputs.
    task automatic idle;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        cin = 1'($urandom); acc_clr = 1'($urandom);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] s, input logic co,
                           input logic ov, input logic st);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(sum),       32'(s));
        chk({tag, "_cout"},  32'(cout),      32'(co));
        chk({tag, "_ovf"},   32'(ovf),       32'(ov));
        chk({tag, "_sat"},   32'(sat),       32'(st));
    endtask

    // One isolated beat: not visible after the capturing edge, visible after the next.
    task automatic single(input string tag, input logic [1:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic c, input logic cl,
                          input logic [15:0] s, input logic co, input logic ov, input logic st);
        drive(o, x, y, c, cl);
        tick;
        idle;
        chk({tag, "_lat"}, 32'(out_valid), 32'd0);
        tick;
        chk_out(tag, s, co, ov, st);
    endtask

    initial begin
        int acc_m;
        int nxt;
        logic sat_m;

        rst = 1'b1; out_ready = 1'b1;
        idle;
        tick; tick;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(sum),       32'd0);
        chk("rst_flags", 32'({cout, ovf, sat}), 32'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // ADD / SUB / ABSDIFF
        single("add_ff_01",  ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
        single("add_7f_01c", ADD, 8'h7F, 8'h01, 1'b1, 1'b0, 16'h0081, 1'b0, 1'b1, 1'b0);
        single("sub_80_01",  SUB, 8'h80, 8'h01, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, 1'b0);
        single("sub_03_05",  SUB, 8'h03, 8'h05, 1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b0);
        single("sub_nocin",  SUB, 8'h05, 8'h03, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        single("abs_3_10",   ABS, 8'd3,  8'd10, 1'b1, 1'b0, 16'd7,    1'b0, 1'b0, 1'b0);
        single("abs_10_3",   ABS, 8'd10, 8'd3,  1'b0, 1'b0, 16'd7,    1'b1, 1'b0, 1'b0);
        single("abs_eq",     ABS, 8'h55, 8'h55, 1'b1, 1'b0, 16'd0,    1'b1, 1'b0, 1'b0);

        // Back-to-back ACCUM beats
        drive(ACC, 8'd10, 8'd3, 1'b0, 1'b1); tick;
        drive(ACC, 8'd2,  8'd9, 1'b0, 1'b0); tick;
        chk_out("acc_1", 16'd7, 1'b1, 1'b0, 1'b0);
        drive(ACC, 8'd200, 8'd0, 1'b0, 1'b0); tick;
        chk_out("acc_2", 16'd14, 1'b0, 1'b0, 1'b0);
        idle; tick;
        chk_out("acc_3", 16'd214, 1'b1, 1'b0, 1'b0);
        tick;
        chk("acc_bubble", 32'(out_valid), 32'd0);
        single("add_mid", ADD, 8'd1, 8'd1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0);
        single("acc_keep", ACC, 8'd1, 8'd0, 1'b0, 1'b0, 16'd215, 1'b1, 1'b0, 1'b0);

        // Saturation: 260 beats of |a-b|=255, first with clear
        acc_m = 0; sat_m = 1'b0;
        for (int i = 0; i <= 260; i++) begin
            if (i < 260) drive(ACC, 8'd255, 8'd0, 1'b0, i == 0);
            else idle;
            tick;
            if (i >= 1) begin
                nxt = acc_m + 255;
                if (nxt > 65535) begin acc_m = 65535; sat_m = 1'b1; end
                else begin acc_m = nxt; sat_m = 1'b0; end
                chk_out($sformatf("sat_%0d", i), 16'(acc_m), 1'b1, 1'b0, sat_m);
            end
        end
        single("sat_clr", ACC, 8'd5, 8'd0, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 1'b0);

        // Backpressure: stall with r1 on the output and b2 in S1
        drive(ADD, 8'd1, 8'd1, 1'b0, 1'b0); tick;
        drive(ADD, 8'd2, 8'd2, 1'b0, 1'b0); tick;
        drive(ADD, 8'd3, 8'd3, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_out($sformatf("bp_hold%0d", i), 16'd2, 1'b0, 1'b0, 1'b0);
            chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick;
        idle;
        chk_out("bp_r2", 16'd4, 1'b0, 1'b0, 1'b0);
        tick;
        chk_out("bp_r3", 16'd6, 1'b0, 1'b0, 1'b0);
        tick;
        chk("bp_drain", 32'(out_valid), 32'd0);
        tick;
        chk("bp_nodup", 32'(out_valid), 32'd0);

        // Reset with beats in flight; acc is 5 beforehand
        drive(ACC, 8'd10, 8'd0, 1'b0, 1'b0); tick;
        drive(ACC, 8'd20, 8'd0, 1'b0, 1'b0); tick;
        chk_out("rf_pre", 16'd15, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        drive(ACC, 8'd100, 8'd0, 1'b0, 1'b0);
        tick;
        chk("rf_valid", 32'(out_valid), 32'd0);
        chk("rf_sum",   32'(sum),       32'd0);
        rst = 1'b0;
        idle;
        tick;
        chk("rf_ghost1", 32'(out_valid), 32'd0);
        tick;
        chk("rf_ghost2", 32'(out_valid), 32'd0);
        single("rf_acc", ACC, 8'd4, 8'd1, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
